// File: rtl/ctrl_serializador.sv
// Sequencer that loads a nibble into the 4-bit universal shift register and shifts it out.
// Optional feature: define PARITY_EN to append a parity bit (frame becomes 5 bits).
module ctrl_serializador #(
    parameter int unsigned GAP_CYCLES = 1,
    parameter bit          FILL_BIT   = 1'b0
`ifdef PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] data_in_i,
    input  logic       data_valid_i,
    input  logic       dir_sel_i,
    input  logic       abort_i,
    output logic       data_ready_o,
    output logic [3:0] d_o,
    output logic [1:0] modo_o,
    output logic       dir_o,
    output logic       enb_o,
    output logic       s_in_o,
    output logic       bit_valid_o,
    output logic [2:0] bit_idx_o,
    output logic       frame_done_o,
    output logic       busy_o
);

    // state | meaning
    // IDLE  | ready for a nibble, register idle
    // LOAD  | register parallel-loads the latched nibble
    // SHIFT | one frame bit on the register's serial output per cycle
    // GAP   | register held, inter-frame spacing
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

`ifdef PARITY_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif
    localparam logic [2:0] GAP_LEN = 3'(GAP_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] data_q, data_d;
    logic       dir_q, dir_d;
    logic [2:0] cnt_q, cnt_d;
    logic       ready_q, ready_d;
    logic [1:0] modo_q, modo_d;
    logic       enb_q, enb_d;
    logic       s_in_q, s_in_d;
    logic       bv_q, bv_d;
    logic [2:0] idx_q, idx_d;
    logic       fd_q, fd_d;
    logic       busy_q, busy_d;
`ifdef PARITY_EN
    logic       par_q, par_d;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
`ifdef PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (data_valid_i && ready_q) begin
                    data_d  = data_in_i;
                    dir_d   = dir_sel_i;
`ifdef PARITY_EN
                    par_d   = PARITY_ODD ? ~^data_in_i : ^data_in_i;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = SHIFT;
                cnt_d   = 3'd0;
            end
            SHIFT: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = (GAP_LEN == 3'd0) ? IDLE : GAP;
                    cnt_d   = GAP_LEN - 3'd1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            GAP: begin
                // gap timer counts down to terminal count 0
                if (cnt_q == 3'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            default: state_d = IDLE;
        endcase
        if (abort_i && (state_q != IDLE)) state_d = IDLE;
        if (state_d == IDLE) cnt_d = 3'd0;

        // outputs are decoded from the next state so they land in flops
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        enb_d   = (state_d == LOAD) || (state_d == SHIFT);
        modo_d  = (state_d == LOAD) ? 2'b10 : 2'b00;
        bv_d    = (state_d == SHIFT);
        idx_d   = (state_d == SHIFT) ? cnt_d : 3'd0;
        fd_d    = (state_d == SHIFT) && (cnt_d == LAST_IDX);
        s_in_d  = FILL_BIT;
`ifdef PARITY_EN
        // parity enters the far end on the first shift and exits after four more
        if ((state_d == SHIFT) && (cnt_d == 3'd0)) s_in_d = par_d;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            data_q  <= 4'd0;
            dir_q   <= 1'b0;
            cnt_q   <= 3'd0;
            ready_q <= 1'b0;
            modo_q  <= 2'b00;
            enb_q   <= 1'b0;
            s_in_q  <= 1'b0;
            bv_q    <= 1'b0;
            idx_q   <= 3'd0;
            fd_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            modo_q  <= modo_d;
            enb_q   <= enb_d;
            s_in_q  <= s_in_d;
            bv_q    <= bv_d;
            idx_q   <= idx_d;
            fd_q    <= fd_d;
            busy_q  <= busy_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign data_ready_o = ready_q;
    assign d_o          = data_q;
    assign dir_o        = dir_q;
    assign modo_o       = modo_q;
    assign enb_o        = enb_q;
    assign s_in_o       = s_in_q;
    assign bit_valid_o  = bv_q;
    assign bit_idx_o    = idx_q;
    assign frame_done_o = fd_q;
    assign busy_o       = busy_q;

endmodule
